// File: rtl/handshake_elastic_fifo.sv
// handshake_elastic_fifo: opaque DEPTH-entry valid/ready FIFO that cuts all combinational handshake paths
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] full_cnt = (AW + 1)'(DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q, count_d;
    logic push, pop;
    assign ins_ready  = count_q != full_cnt;
    assign outs_valid = count_q != '0;
    assign outs       = mem_q[rd_ptr_q];
    assign push       = ins_valid && ins_ready;
    assign pop        = outs_valid && outs_ready;
    // next-state: write on push, advance pointers, track occupancy
    always_comb begin
        mem_d    = mem_q;
        mem_d[wr_ptr_q] = push ? ins : mem_q[wr_ptr_q];
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
    // state registers; reset clears storage so outs reads 0 immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule
